// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: deframes SYNC/ADDR/LEN/DATA packets from the UART byte stream into handshaked memory writes.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte (S_CHK) on every packet.
module uart_cmd_ctrl #(
    parameter int         ADDR_W       = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 870000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    input  logic              i_Wr_Ready,
    output logic              o_Busy,
    output logic              o_Pkt_Done,
    output logic              o_Pkt_Err,
    output logic [1:0]        o_Err_Code
);
    localparam int TIMER_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_CHK,
        S_FLUSH
    } state_t;

    state_t             state, state_next;
    logic [7:0]         addr_hi;
    logic [ADDR_W-1:0]  addr;
    logic [8:0]         remaining;
    logic [TIMER_W-1:0] timer;
    logic               timed, abort, done_set, issue, wr_accept;
    logic [1:0]         abort_code;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]         chk;
`endif

    assign o_Busy = (state != S_IDLE);

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        abort_code = 2'd0;
        done_set   = 1'b0;
        issue      = 1'b0;
        wr_accept  = o_Wr_En & i_Wr_Ready;
        timed      = (state != S_IDLE) && (state != S_FLUSH);
        case (state)
            S_IDLE:    if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_next = S_ADDR_HI;
            S_ADDR_HI: if (i_Rx_DV) state_next = S_ADDR_LO;
            S_ADDR_LO: if (i_Rx_DV) state_next = S_LEN;
            S_LEN:     if (i_Rx_DV) state_next = S_DATA;
            S_DATA: begin
                // A new byte while the previous write is still refused has nowhere to go.
                if (i_Rx_DV) begin
                    if (o_Wr_En && !i_Wr_Ready) begin
                        abort      = 1'b1;
                        abort_code = 2'd2;
                    end else begin
                        issue = 1'b1;
                        if (remaining == 9'd1) begin
`ifdef UART_CMD_CHECKSUM_EN
                            state_next = S_CHK;
`else
                            state_next = S_FLUSH;
`endif
                        end
                    end
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != chk) begin
                        abort      = 1'b1;
                        abort_code = 2'd3;
                    end else begin
                        state_next = S_FLUSH;
                    end
                end
            end
`endif
            S_FLUSH: begin
                if (!o_Wr_En) begin
                    done_set   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (timed && !i_Rx_DV && timer == TIMER_LAST) begin
            abort      = 1'b1;
            abort_code = 2'd1;
        end
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            addr_hi    <= 8'd0;
            addr       <= '0;
            remaining  <= 9'd0;
            timer      <= '0;
            o_Wr_En    <= 1'b0;
            o_Wr_Addr  <= '0;
            o_Wr_Data  <= 8'd0;
            o_Pkt_Done <= 1'b0;
            o_Pkt_Err  <= 1'b0;
            o_Err_Code <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
            chk        <= 8'd0;
`endif
        end else begin
            state      <= state_next;
            o_Pkt_Done <= done_set;
            o_Pkt_Err  <= abort;
            timer      <= (!timed || i_Rx_DV) ? '0 : timer + 1'b1;

            if (abort)
                o_Err_Code <= abort_code;
            else if (state == S_IDLE && i_Rx_DV && i_Rx_Byte == SYNC_BYTE)
                o_Err_Code <= 2'd0;

            // An abort cancels any pending write; otherwise a new byte replaces an accepted one.
            if (abort) begin
                o_Wr_En <= 1'b0;
            end else if (issue) begin
                o_Wr_En   <= 1'b1;
                o_Wr_Addr <= addr;
                o_Wr_Data <= i_Rx_Byte;
            end else if (wr_accept) begin
                o_Wr_En <= 1'b0;
            end

            if (i_Rx_DV && !abort) begin
                case (state)
                    S_ADDR_HI: addr_hi <= i_Rx_Byte;
                    S_ADDR_LO: addr <= ADDR_W'({addr_hi, i_Rx_Byte});
                    S_LEN:     remaining <= (i_Rx_Byte == 8'd0) ? 9'd256 : {1'b0, i_Rx_Byte};
                    S_DATA: begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 9'd1;
                    end
                    default: ;
                endcase
`ifdef UART_CMD_CHECKSUM_EN
                if (state == S_ADDR_HI)
                    chk <= i_Rx_Byte;
                else if (state == S_ADDR_LO || state == S_LEN || state == S_DATA)
                    chk <= chk ^ i_Rx_Byte;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl; accepted writes and Done/Err pulses are collected on the falling edge.
// Sends the trailing checksum byte when UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_ctrl;
    localparam int ADDR_W = 16;
    localparam int TO     = 40;

    logic              i_Clock    = 1'b0;
    logic              i_Reset    = 1'b1;
    logic              i_Rx_DV    = 1'b0;
    logic [7:0]        i_Rx_Byte  = 8'd0;
    logic              i_Wr_Ready = 1'b0;
    logic              o_Wr_En;
    logic [ADDR_W-1:0] o_Wr_Addr;
    logic [7:0]        o_Wr_Data;
    logic              o_Busy, o_Pkt_Done, o_Pkt_Err;
    logic [1:0]        o_Err_Code;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [23:0] wq[$];

    uart_cmd_ctrl #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data), .i_Wr_Ready(i_Wr_Ready),
        .o_Busy(o_Busy), .o_Pkt_Done(o_Pkt_Done), .o_Pkt_Err(o_Pkt_Err), .o_Err_Code(o_Err_Code)
    );

    always #5 i_Clock = ~i_Clock;

    always @(negedge i_Clock) begin
        if (o_Wr_En && i_Wr_Ready) wq.push_back({o_Wr_Addr, o_Wr_Data});
        if (o_Pkt_Done) done_cnt++;
        if (o_Pkt_Err) err_cnt++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick(1);
        i_Rx_DV   = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] len);
        send_byte(8'hA5); tick(1);
        send_byte(hi);    tick(1);
        send_byte(lo);    tick(1);
        send_byte(len);   tick(1);
    endtask

    task automatic wait_done(input int base, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_err(input int base, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (err_cnt > base) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        i_Reset = 1'b1;
        tick(2);
        checks++;
        if ({o_Wr_En, o_Busy, o_Pkt_Done, o_Pkt_Err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {o_Wr_En, o_Busy, o_Pkt_Done, o_Pkt_Err});
        end
        checks++;
        if (o_Err_Code !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_code: got %0d want 0", o_Err_Code);
        end
        checks++;
        if ({o_Wr_Addr, o_Wr_Data} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr_data: got %h want 000000", {o_Wr_Addr, o_Wr_Data});
        end
        i_Reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        logic [7:0] chk;
        int d0, e0;
        bit ok;
        chk = 8'h12 ^ 8'h34 ^ 8'h02 ^ 8'hAA ^ 8'hBB;
        d0 = done_cnt; e0 = err_cnt;
        i_Wr_Ready = 1'b1;
        wq.delete();
        send_byte(8'hA5);
        checks++;
        if (o_Busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy: got %b want 1", o_Busy);
        end
        tick(1);
        send_byte(8'h12); tick(1); send_byte(8'h34); tick(1); send_byte(8'h02); tick(1);
        send_byte(8'hAA); tick(1); send_byte(8'hBB); tick(1);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(chk); tick(1);
`endif
        wait_done(d0, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_done_seen: got %b want 1", ok);
        end
        tick(2);
        checks++;
        if (wq.size() != 2 || wq[0] !== 24'h1234AA || wq[1] !== 24'h1235BB) begin
            errors++;
            $display("[TB] FAIL basic_writes: got %0d writes want 2 (1234AA,1235BB)", wq.size());
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL basic_pulses: got done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({o_Busy, o_Err_Code} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL basic_idle: got busy/code %b want 000", {o_Busy, o_Err_Code});
        end
    endtask

    task automatic test_wrap;
        logic [7:0] chk;
        int d0;
        bit ok;
        chk = 8'hFF ^ 8'hFF ^ 8'h03 ^ 8'h01 ^ 8'h02 ^ 8'h03;
        d0 = done_cnt;
        i_Wr_Ready = 1'b1;
        wq.delete();
        send_hdr(8'hFF, 8'hFF, 8'h03);
        send_byte(8'h01); tick(1); send_byte(8'h02); tick(1); send_byte(8'h03); tick(1);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(chk); tick(1);
`endif
        wait_done(d0, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_done_seen: got %b want 1", ok);
        end
        checks++;
        if (wq.size() != 3 || wq[0] !== 24'hFFFF01 || wq[1] !== 24'h000002 || wq[2] !== 24'h000103) begin
            errors++;
            $display("[TB] FAIL wrap_writes: got %0d writes want 3 (FFFF01,000002,000103)", wq.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] chk;
        int d0, e0;
        bit ok;
        chk = 8'h40 ^ 8'h00 ^ 8'h03 ^ 8'h10 ^ 8'h20 ^ 8'h30;
        d0 = done_cnt; e0 = err_cnt;
        i_Wr_Ready = 1'b1;
        wq.delete();
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(chk);
`endif
        wait_done(d0, 20, ok);
        checks++;
        if (ok !== 1'b1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_done: got done %b err %0d want 1 0", ok, err_cnt - e0);
        end
        checks++;
        if (wq.size() != 3 || wq[0] !== 24'h400010 || wq[1] !== 24'h400120 || wq[2] !== 24'h400230) begin
            errors++;
            $display("[TB] FAIL b2b_writes: got %0d writes want 3 (400010,400120,400230)", wq.size());
        end
    endtask

    task automatic test_len_zero;
        logic [7:0] chk;
        int d0, bad;
        bit ok;
        chk = 8'h20 ^ 8'h00 ^ 8'h00;
        d0 = done_cnt;
        bad = 0;
        i_Wr_Ready = 1'b1;
        wq.delete();
        send_hdr(8'h20, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            chk = chk ^ 8'(i);
        end
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(chk);
`endif
        wait_done(d0, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL len0_done_seen: got %b want 1", ok);
        end
        if (wq.size() == 256) begin
            for (int i = 0; i < 256; i++)
                if (wq[i] !== {16'h2000 + 16'(i), 8'(i)}) bad++;
        end else begin
            bad = 1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL len0_writes: got %0d writes (%0d bad) want 256 at 2000..20FF", wq.size(), bad);
        end
    endtask

    task automatic test_flush_wait;
        int d0;
        bit ok;
        d0 = done_cnt;
        i_Wr_Ready = 1'b0;
        wq.delete();
        send_hdr(8'h50, 8'h00, 8'h01);
        send_byte(8'h77); tick(1);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h50 ^ 8'h00 ^ 8'h01 ^ 8'h77); tick(1);
`endif
        tick(5);
        checks++;
        if (done_cnt - d0 !== 0 || o_Busy !== 1'b1 || o_Wr_En !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_hold: got done %0d busy %b wr_en %b want 0 1 1", done_cnt - d0, o_Busy, o_Wr_En);
        end
        checks++;
        if ({o_Wr_Addr, o_Wr_Data} !== 24'h500077) begin
            errors++;
            $display("[TB] FAIL flush_pending: got %h want 500077", {o_Wr_Addr, o_Wr_Data});
        end
        i_Wr_Ready = 1'b1;
        wait_done(d0, 10, ok);
        checks++;
        if (ok !== 1'b1 || wq.size() != 1 || wq[0] !== 24'h500077) begin
            errors++;
            $display("[TB] FAIL flush_release: got done %b writes %0d want 1 1", ok, wq.size());
        end
    endtask

    task automatic test_timeout;
        int e0, d0;
        bit ok;
        e0 = err_cnt;
        i_Wr_Ready = 1'b1;
        send_byte(8'hA5); tick(1); send_byte(8'h00); tick(1); send_byte(8'h10);
        tick(TO - 5);
        checks++;
        if (err_cnt - e0 !== 0 || o_Busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_early: got err %0d busy %b want 0 1", err_cnt - e0, o_Busy);
        end
        wait_err(e0, 20, ok);
        checks++;
        if (ok !== 1'b1 || o_Err_Code !== 2'd1 || o_Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got err %b code %0d busy %b want 1 1 0", ok, o_Err_Code, o_Busy);
        end
        tick(3);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse_len: got %0d want 1", err_cnt - e0);
        end
        d0 = done_cnt;
        wq.delete();
        send_byte(8'hA5);
        checks++;
        if (o_Err_Code !== 2'd0) begin
            errors++;
            $display("[TB] FAIL timeout_code_clear: got %0d want 0", o_Err_Code);
        end
        tick(1);
        send_byte(8'h00); tick(1); send_byte(8'h10); tick(1); send_byte(8'h01); tick(1);
        send_byte(8'h99); tick(1);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h00 ^ 8'h10 ^ 8'h01 ^ 8'h99); tick(1);
`endif
        wait_done(d0, 20, ok);
        checks++;
        if (ok !== 1'b1 || wq.size() != 1 || wq[0] !== 24'h001099) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got done %b writes %0d want 1 1", ok, wq.size());
        end
    endtask

    task automatic test_overrun;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        i_Wr_Ready = 1'b0;
        wq.delete();
        send_hdr(8'h00, 8'h20, 8'h02);
        send_byte(8'h11); tick(1);
        send_byte(8'h22);
        checks++;
        if (o_Pkt_Err !== 1'b1 || o_Err_Code !== 2'd2) begin
            errors++;
            $display("[TB] FAIL overrun_err: got err %b code %0d want 1 2", o_Pkt_Err, o_Err_Code);
        end
        checks++;
        if (o_Wr_En !== 1'b0 || o_Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_idle: got wr_en %b busy %b want 0 0", o_Wr_En, o_Busy);
        end
        tick(3);
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL overrun_after: got err %0d done %0d writes %0d want 1 0 0", err_cnt - e0, done_cnt - d0, wq.size());
        end
        i_Wr_Ready = 1'b1;
    endtask

`ifdef UART_CMD_CHECKSUM_EN
    task automatic test_chk_bad;
        int d0;
        d0 = done_cnt;
        i_Wr_Ready = 1'b1;
        send_hdr(8'h12, 8'h34, 8'h02);
        send_byte(8'hAA); tick(1); send_byte(8'hBB); tick(1);
        send_byte(8'h00);
        checks++;
        if (o_Pkt_Err !== 1'b1 || o_Err_Code !== 2'd3) begin
            errors++;
            $display("[TB] FAIL chk_bad_err: got err %b code %0d want 1 3", o_Pkt_Err, o_Err_Code);
        end
        tick(5);
        checks++;
        if (done_cnt - d0 !== 0 || o_Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chk_bad_nodone: got done %0d busy %b want 0 0", done_cnt - d0, o_Busy);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int d0, e0;
        bit ok;
        i_Wr_Ready = 1'b0;
        send_hdr(8'h60, 8'h00, 8'h02);
        send_byte(8'h55); tick(1);
        checks++;
        if (o_Wr_En !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_pending: got %b want 1", o_Wr_En);
        end
        d0 = done_cnt; e0 = err_cnt;
        i_Reset = 1'b1;
        tick(1);
        checks++;
        if ({o_Wr_En, o_Busy, o_Pkt_Done, o_Pkt_Err, o_Err_Code} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %b want 000000", {o_Wr_En, o_Busy, o_Pkt_Done, o_Pkt_Err, o_Err_Code});
        end
        i_Reset = 1'b0;
        tick(3);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL rstmid_nopulse: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        i_Wr_Ready = 1'b1;
        wq.delete();
        send_hdr(8'h60, 8'h00, 8'h01);
        send_byte(8'h66); tick(1);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h60 ^ 8'h00 ^ 8'h01 ^ 8'h66); tick(1);
`endif
        wait_done(d0, 20, ok);
        checks++;
        if (ok !== 1'b1 || wq.size() != 1 || wq[0] !== 24'h600066) begin
            errors++;
            $display("[TB] FAIL rstmid_next_pkt: got done %b writes %0d want 1 1", ok, wq.size());
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_len_zero();
        test_flush_wait();
        test_timeout();
        test_overrun();
`ifdef UART_CMD_CHECKSUM_EN
        test_chk_bad();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
